// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared types and sizing helpers for the 2R1W register file
// Rev 1.0
// ============================================================================
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w_if.sv
`default_nettype none
// ============================================================================
// regfile_2r1w_if : read/write port bundle between decode/writeback and regfile
// Rev 1.0
// ============================================================================
interface regfile_2r1w_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
);

  localparam int AW = addr_width(NREGS);

  logic [AW-1:0]   raddr_a;
  logic [AW-1:0]   raddr_b;
  logic            re;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            we;
  logic [XLEN-1:0] rdata_a;
  logic [XLEN-1:0] rdata_b;
  logic            ready;

  modport master (
    output raddr_a, raddr_b, re, waddr, wdata, we,
    input  rdata_a, rdata_b, ready
  );

  modport slave (
    input  raddr_a, raddr_b, re, waddr, wdata, we,
    output rdata_a, rdata_b, ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_clear_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_clear_ctrl : post-reset sequencer that walks entries 1..NREGS-1
// Rev 1.0
// ============================================================================
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  output logic               ready,
  output logic               clear_we,
  output logic [AW-1:0]      clear_addr
);

  localparam logic [AW-1:0] C_PTR_INIT = AW'(1);
  localparam logic [AW-1:0] C_PTR_LAST = AW'(NREGS - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q,   ptr_d;
  logic          ready_q, ready_d;

  // Pointer parks on the last entry once the sweep is done; it never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (state_q == ST_CLEAR) begin
      if (ptr_q == C_PTR_LAST) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= C_PTR_INIT;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign clear_we   = (state_q == ST_CLEAR);
  assign clear_addr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// regfile_2r1w : XLEN x NREGS integer register file, 2 registered reads, 1 write
// Rev 1.0
// ============================================================================
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  regfile_2r1w_if.slave    bus
);

  localparam int AW = addr_width(NREGS);

  logic            ready;
  logic            clear_we;
  logic [AW-1:0]   clear_addr;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic            byp_a;
  logic            byp_b;

  logic [XLEN-1:0] rdata_a_q, rdata_a_d;
  logic [XLEN-1:0] rdata_b_q, rdata_b_d;

  // x0 has no storage; valid indices are 1..NREGS-1.
  logic [XLEN-1:0] mem [1:NREGS-1];

  regfile_clear_ctrl #(
    .NREGS (NREGS)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  // clear_we is only high while ready is low, so the two writers never collide.
  assign wr_en   = !rst && (clear_we || (ready && bus.we && (bus.waddr != '0)));
  assign wr_addr = clear_we ? clear_addr : bus.waddr;
  assign wr_data = clear_we ? '0 : bus.wdata;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (BYPASS != 0) begin : g_bypass
    assign byp_a = bus.we && (bus.waddr == bus.raddr_a);
    assign byp_b = bus.we && (bus.waddr == bus.raddr_b);
  end else begin : g_no_bypass
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (!ready) begin
      rdata_a_d = '0;
      rdata_b_d = '0;
    end else if (bus.re) begin
      if (bus.raddr_a == '0) begin
        rdata_a_d = '0;
      end else if (byp_a) begin
        rdata_a_d = bus.wdata;
      end else begin
        rdata_a_d = mem[bus.raddr_a];
      end
      if (bus.raddr_b == '0) begin
        rdata_b_d = '0;
      end else if (byp_b) begin
        rdata_b_d = bus.wdata;
      end else begin
        rdata_b_d = mem[bus.raddr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.ready   = ready;

endmodule
`default_nettype wire
